// File: rtl/piso_shift_tx.sv
// MSB-first parallel-to-serial transmitter with valid/ready load and a done pulse.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_shift_tx #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          shreg_d = in_data;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        // Counter holds at its last value so it never wraps past WIDTH-1.
        if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    sout_valid = (state_q != IDLE);
    sout       = 1'b0;
    case (state_q)
      SHIFT:   sout = shreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
      PARITY:  sout = par_q;
`endif
      default: sout = 1'b0;
    endcase
  end

  assign done = done_q;

endmodule
